// File: rtl/pattern_dac_seq.sv
// Multi-level pattern sequencer for an AD974x DAC bus: plays a stored amplitude pattern with
// per-step dwell, inter-burst gap and burst count. Optional macro: PAT_OFFSET_BIN_EN.
module pattern_dac_seq #(
    parameter int                   DAC_WIDTH = 8,
    parameter int                   DEPTH     = 8,
    parameter int                   DWELL_W   = 8,
    parameter int                   GAP_W     = 16,
    parameter int                   BURST_W   = 8,
    parameter logic [DAC_WIDTH-1:0] IDLE_CODE = '0,
    localparam int                  AW        = $clog2(DEPTH)
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 wr_en,
    input  logic [AW-1:0]        wr_addr,
    input  logic [DAC_WIDTH-1:0] wr_data,
    input  logic                 en,
    input  logic                 abort,
    input  logic [AW:0]          pat_len,
    input  logic [DWELL_W-1:0]   dwell,
    input  logic [GAP_W-1:0]     gap,
    input  logic [BURST_W-1:0]   burst_num,
    output logic [DAC_WIDTH-1:0] dac_data,
    output logic                 busy,
    output logic                 burst_done,
    output logic                 done,
    output logic                 wr_err,
    output logic [1:0]           dbg_state
);

`ifdef PAT_OFFSET_BIN_EN
    localparam logic [DAC_WIDTH-1:0] CODE_XOR = {1'b1, {(DAC_WIDTH-1){1'b0}}};
`else
    localparam logic [DAC_WIDTH-1:0] CODE_XOR = '0;
`endif
    localparam logic [DAC_WIDTH-1:0] IDLE_OUT = IDLE_CODE ^ CODE_XOR;
    localparam logic [AW:0]          LEN_ONE  = (AW+1)'(1);
    localparam logic [AW:0]          LEN_MAX  = (AW+1)'(DEPTH);

    typedef enum logic [1:0] {S_IDLE, S_PLAY, S_GAP, S_FINISH} state_t;

    state_t               r_state, w_state_nxt;
    logic [DAC_WIDTH-1:0] r_pat [DEPTH];
    logic [AW-1:0]        r_step, w_step_nxt;
    logic [DWELL_W-1:0]   r_dwell_cnt, w_dwell_nxt, r_dwell, w_dwell_use;
    logic [GAP_W-1:0]     r_gap_cnt, w_gap_nxt, r_gap;
    logic [BURST_W-1:0]   r_burst_cnt, w_burst_cnt_nxt, r_burst_num, w_burst_inc;
    logic [AW:0]          r_len, w_len_clamped, w_len_use;
    logic [DAC_WIDTH-1:0] r_dac, w_dac_nxt;
    logic                 r_busy, r_burst_done, r_done, r_wr_err, r_en_d, r_stop_req;
    logic                 w_bd_nxt, w_step_end, w_burst_end, w_last_burst, w_gap_end, w_load;
    logic [31:0]          w_len_in, w_wr_idx;

    assign w_len_in = 32'(pat_len);
    assign w_wr_idx = 32'(wr_addr);

    always_comb begin
        w_len_clamped = pat_len;
        if (w_len_in == 32'd0)
            w_len_clamped = LEN_ONE;
        else if (w_len_in > 32'(DEPTH))
            w_len_clamped = LEN_MAX;
    end

    // Counters describe the sample currently on dac_data.
    assign w_step_end   = (r_dwell_cnt == r_dwell);
    assign w_burst_end  = w_step_end && ({1'b0, r_step} == r_len - LEN_ONE);
    assign w_burst_inc  = r_burst_cnt + 1'b1;
    assign w_last_burst = (r_burst_num != '0) && (w_burst_inc == r_burst_num);
    assign w_gap_end    = (r_gap_cnt == r_gap - 1'b1);
    assign w_load       = (r_state == S_IDLE) && en;
    assign w_dwell_use  = (r_state == S_IDLE) ? dwell : r_dwell;
    assign w_len_use    = (r_state == S_IDLE) ? w_len_clamped : r_len;

    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            r_state <= S_IDLE;
        else
            r_state <= w_state_nxt;
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE:   if (en) w_state_nxt = S_PLAY;
            S_PLAY: begin
                if (abort)
                    w_state_nxt = S_FINISH;
                else if (w_burst_end) begin
                    if (w_last_burst || r_stop_req) w_state_nxt = S_FINISH;
                    else if (r_gap == '0)           w_state_nxt = S_PLAY;
                    else                            w_state_nxt = S_GAP;
                end
            end
            S_GAP: begin
                if (abort || r_stop_req) w_state_nxt = S_FINISH;
                else if (w_gap_end)      w_state_nxt = S_PLAY;
            end
            default:  w_state_nxt = S_IDLE;
        endcase
    end

    always_comb begin
        w_step_nxt      = '0;
        w_dwell_nxt     = '0;
        w_gap_nxt       = '0;
        w_dac_nxt       = IDLE_OUT;
        w_burst_cnt_nxt = r_burst_cnt;
        case (w_state_nxt)
            S_PLAY: begin
                if (r_state == S_PLAY && !w_step_end) begin
                    w_step_nxt  = r_step;
                    w_dwell_nxt = r_dwell_cnt + 1'b1;
                end else if (r_state == S_PLAY && !w_burst_end) begin
                    w_step_nxt  = r_step + 1'b1;
                end
                w_dac_nxt = r_pat[w_step_nxt] ^ CODE_XOR;
            end
            S_GAP: if (r_state == S_GAP) w_gap_nxt = r_gap_cnt + 1'b1;
            default: ;
        endcase
        if (r_state != S_PLAY && r_state != S_GAP)
            w_burst_cnt_nxt = '0;
        else if (r_state == S_PLAY && w_burst_end && !abort)
            w_burst_cnt_nxt = w_burst_inc;
        w_bd_nxt = (w_state_nxt == S_PLAY) && (w_dwell_nxt == w_dwell_use)
                   && ({1'b0, w_step_nxt} == w_len_use - LEN_ONE);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_pat        <= '{default: '0};
            r_step       <= '0;
            r_dwell_cnt  <= '0;
            r_gap_cnt    <= '0;
            r_burst_cnt  <= '0;
            r_len        <= LEN_ONE;
            r_dwell      <= '0;
            r_gap        <= '0;
            r_burst_num  <= '0;
            r_dac        <= IDLE_OUT;
            r_busy       <= 1'b0;
            r_burst_done <= 1'b0;
            r_done       <= 1'b0;
            r_wr_err     <= 1'b0;
            r_en_d       <= 1'b0;
            r_stop_req   <= 1'b0;
        end else begin
            r_step       <= w_step_nxt;
            r_dwell_cnt  <= w_dwell_nxt;
            r_gap_cnt    <= w_gap_nxt;
            r_burst_cnt  <= w_burst_cnt_nxt;
            r_dac        <= w_dac_nxt;
            r_busy       <= (w_state_nxt == S_PLAY) || (w_state_nxt == S_GAP);
            r_burst_done <= w_bd_nxt;
            r_done       <= (w_state_nxt == S_FINISH);
            r_wr_err     <= wr_en && r_busy;
            r_en_d       <= en;
            r_stop_req   <= (r_state == S_PLAY || r_state == S_GAP) ? (r_stop_req | (r_en_d & ~en)) : 1'b0;
            if (w_load) begin
                r_len       <= w_len_clamped;
                r_dwell     <= dwell;
                r_gap       <= gap;
                r_burst_num <= burst_num;
            end
            // Step 0 is read on the start edge, so a same-edge write to step 0 shows next burst.
            if (wr_en && !r_busy && w_wr_idx < 32'(DEPTH))
                r_pat[wr_addr] <= wr_data;
        end
    end

    assign dac_data   = r_dac;
    assign busy       = r_busy;
    assign burst_done = r_burst_done;
    assign done       = r_done;
    assign wr_err     = r_wr_err;
    assign dbg_state  = r_state;

endmodule

// File: tb/tb_pattern_dac_seq.sv
// Bench for pattern_dac_seq: builds the expected per-cycle output trace of each run from the
// pattern/dwell/gap/burst rules and compares every busy cycle, plus literal spot checks.
module tb_pattern_dac_seq;
    localparam int DW = 8, DEPTH = 8, AW = 3, W = DW + 4;

    logic          clk = 1'b0;
    logic          rst, wr_en, en, abort;
    logic [AW-1:0] wr_addr;
    logic [DW-1:0] wr_data, dac_data;
    logic [AW:0]   pat_len;
    logic [7:0]    dwell, burst_num;
    logic [15:0]   gap;
    logic          busy, burst_done, done, wr_err;
    logic [1:0]    dbg_state;

    pattern_dac_seq dut (
        .clk(clk), .rst(rst), .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
        .en(en), .abort(abort), .pat_len(pat_len), .dwell(dwell), .gap(gap),
        .burst_num(burst_num), .dac_data(dac_data), .busy(busy), .burst_done(burst_done),
        .done(done), .wr_err(wr_err), .dbg_state(dbg_state)
    );

    always #5 clk = ~clk;

    logic [W-1:0]  exp_q[$];
    logic [W-1:0]  cmp_e;
    logic [DW-1:0] pat_m [DEPTH];
    logic [DW-1:0] obs [64];
    int            n_checks = 0, n_pass = 0;
    bit            chk_on = 1'b0;
    int            busy_seen, bd_seen, done_seen, obs_n, cyc;
    string         run_name;

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h", nm, act, exp);
    endtask

    function automatic logic [W-1:0] ent(input logic [DW-1:0] d, input bit b, input bit bd,
                                         input bit dn, input bit we);
        return {d, b, bd, dn, we};
    endfunction

    // Expected trace: entry t is the cycle after the t-th edge following the start edge.
    task automatic build(input int len, input int dw, input int gp, input int bursts,
                         input int stop_t, input int abort_t, input int wr_t, output int fin_t);
        int t, b;
        bit fin, last;
        exp_q.delete();
        t = 0; b = 0; fin = 1'b0;
        while (!fin) begin
            for (int s = 0; s < len && !fin; s++)
                for (int d = 0; d <= dw && !fin; d++) begin
                    last = (s == len - 1) && (d == dw);
                    exp_q.push_back(ent(pat_m[s], 1'b1, last, 1'b0, t == wr_t + 1));
                    if (t == abort_t) fin = 1'b1;
                    else if (last && ((bursts != 0 && b + 1 == bursts) || (stop_t >= 0 && t > stop_t)))
                        fin = 1'b1;
                    t++;
                end
            b++;
            for (int g = 0; g < gp && !fin; g++) begin
                exp_q.push_back(ent(8'd0, 1'b1, 1'b0, 1'b0, t == wr_t + 1));
                if (t == abort_t || (stop_t >= 0 && t > stop_t)) fin = 1'b1;
                t++;
            end
        end
        fin_t = t;
        exp_q.push_back(ent(8'd0, 1'b0, 1'b0, 1'b1, t == wr_t + 1));
        exp_q.push_back(ent(8'd0, 1'b0, 1'b0, 1'b0, 1'b0));
    endtask

    always @(negedge clk) begin
        if (chk_on && exp_q.size() != 0) begin
            cmp_e = exp_q.pop_front();
            check($sformatf("%s cyc%0d {dac,busy,bd,done,wr_err}", run_name, cyc),
                  {20'd0, dac_data, busy, burst_done, done, wr_err}, {20'd0, cmp_e});
            if (busy) busy_seen++;
            if (burst_done) bd_seen++;
            if (done) done_seen++;
            if (obs_n < 64) obs[obs_n] = dac_data;
            obs_n++;
            cyc++;
        end
    end

    task automatic write_pat(input int a, input logic [DW-1:0] d);
        wr_en = 1'b1; wr_addr = AW'(a); wr_data = d;
        @(posedge clk); #1;
        wr_en = 1'b0;
        pat_m[a] = d;
        check("idle write wr_err", {31'd0, wr_err}, 32'd0);
    endtask

    task automatic run(input string nm, input int len_in, input int dw, input int gp,
                       input int bursts, input int stop_t, input int abort_t, input int wr_t,
                       input int exp_busy, input int exp_bd);
        int len, fin_t, en_low_t;
        len = (len_in == 0) ? 1 : (len_in > DEPTH) ? DEPTH : len_in;
        build(len, dw, gp, bursts, stop_t, abort_t, wr_t, fin_t);
        en_low_t = (stop_t >= 0) ? stop_t : fin_t;
        run_name = nm; cyc = 0; busy_seen = 0; bd_seen = 0; done_seen = 0; obs_n = 0;
        pat_len = 4'(len_in); dwell = 8'(dw); gap = 16'(gp); burst_num = 8'(bursts);
        en = 1'b1;
        @(posedge clk); #1;
        chk_on = 1'b1;
        for (int t = 0; t <= fin_t + 1; t++) begin
            en      = (t < en_low_t);
            abort   = (t == abort_t);
            wr_en   = (t == wr_t);
            wr_addr = 3'd1;
            wr_data = 8'hEE;
            if (t == 2) begin
                pat_len   = 4'($urandom_range(0, 15));
                dwell     = 8'($urandom_range(0, 255));
                gap       = 16'($urandom_range(0, 65535));
                burst_num = 8'($urandom_range(0, 255));
            end
            @(posedge clk); #1;
        end
        chk_on = 1'b0; en = 1'b0; abort = 1'b0; wr_en = 1'b0;
        check({nm, " trace drained"}, exp_q.size(), 32'd0);
        check({nm, " busy cycles"}, busy_seen, exp_busy);
        check({nm, " burst_done pulses"}, bd_seen, exp_bd);
        check({nm, " done pulses"}, done_seen, 32'd1);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b1; wr_en = 1'b0; en = 1'b0; abort = 1'b0;
        wr_addr = '0; wr_data = '0; pat_len = '0; dwell = '0; gap = '0; burst_num = '0;
        for (int i = 0; i < DEPTH; i++) pat_m[i] = '0;
        #3;
        check("reset dac_data", {24'd0, dac_data}, 32'd0);
        check("reset busy", {31'd0, busy}, 32'd0);
        check("reset burst_done", {31'd0, burst_done}, 32'd0);
        check("reset done", {31'd0, done}, 32'd0);
        check("reset wr_err", {31'd0, wr_err}, 32'd0);
        check("reset state", {30'd0, dbg_state}, 32'd0);
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        @(posedge clk); #1;

        for (int i = 0; i < DEPTH; i++) write_pat(i, 8'(10 * (i + 1)));

        abort = 1'b1;
        @(posedge clk); #1;
        abort = 1'b0;
        check("abort in idle busy", {31'd0, busy}, 32'd0);
        check("abort in idle done", {31'd0, done}, 32'd0);

        run("two_bursts", 4, 1, 3, 2, -1, -5, -5, 19, 2);
        check("two_bursts dac[0]", {24'd0, obs[0]}, 32'd10);
        check("two_bursts dac[3]", {24'd0, obs[3]}, 32'd20);
        check("two_bursts dac[7]", {24'd0, obs[7]}, 32'd40);
        check("two_bursts dac[8]", {24'd0, obs[8]}, 32'd0);
        check("two_bursts dac[11]", {24'd0, obs[11]}, 32'd10);

        run("stop_inf", 4, 1, 0, 0, 19, -5, -5, 24, 3);
        check("stop_inf dac[8]", {24'd0, obs[8]}, 32'd10);

        run("abort", 4, 1, 3, 5, -1, 15, -5, 16, 1);
        check("abort dac[15]", {24'd0, obs[15]}, 32'd30);
        check("abort dac[16]", {24'd0, obs[16]}, 32'd0);

        run("len0", 0, 2, 1, 2, -1, -5, -5, 7, 2);
        run("len15", 15, 0, 0, 1, -1, -5, -5, 8, 1);
        check("len15 dac[7]", {24'd0, obs[7]}, 32'd80);

        run("busy_write", 4, 0, 2, 1, -1, -5, 1, 4, 1);
        run("readback", 4, 0, 2, 1, -1, -5, -5, 4, 1);
        check("readback dac[1]", {24'd0, obs[1]}, 32'd20);

        pat_len = 4'd4; dwell = 8'd1; gap = 16'd0; burst_num = 8'd0; en = 1'b1;
        repeat (3) @(posedge clk);
        #2 rst = 1'b1;
        #1;
        check("midrun reset dac_data", {24'd0, dac_data}, 32'd0);
        check("midrun reset busy", {31'd0, busy}, 32'd0);
        check("midrun reset state", {30'd0, dbg_state}, 32'd0);
        en = 1'b0;
        @(posedge clk); #1;
        rst = 1'b0;
        for (int i = 0; i < DEPTH; i++) pat_m[i] = '0;
        @(posedge clk); #1;
        run("after_reset", 4, 0, 0, 1, -1, -5, -5, 4, 1);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
